sm83_regfile_mp: RTL and testbench
==================================

// Module: sm83_regfile_mp
// PURPOSE
//  Parametrised multi-port successor to the SM83 register file: NUM_PAIRS 16-bit pairs, NUM_RD read
//  ports, NUM_WR byte-lane write ports, a 16-bit increment/decrement port (IDU) and a debug dump sequencer.
//  It sits between the decode/execute datapath and the bus unit.
//  It lets the core retire an ALU write, a load and a pointer post-increment in the same cycle.
// PARAMETERS
//  NUM_PAIRS  6  number of 16-bit pairs (0=BC,1=DE,2=HL,3=AF,4=SP,5=PC); min 4
//  NUM_RD     3  combinational read ports
//  NUM_WR     2  write ports; higher index = higher priority
//  AF_IDX     3  pair index whose low byte is F (F[3:0] hard-wired 0); set >=NUM_PAIRS to disable
//  IDX_W      $clog2(NUM_PAIRS)  derived, pair index width
// PORTS
//  clk         in   1               clock, rising edge
//  rst         in   1               asynchronous reset, active-high
//  wr_en       in   NUM_WR          per-port write enable
//  wr_idx      in   NUM_WR x IDX_W  target pair per port
//  wr_lane     in   NUM_WR x 2      [1]=high byte (B,D,H,A,SPh,PCh), [0]=low byte
//  wr_data     in   NUM_WR x 16     write data; lane-masked
//  rd_idx      in   NUM_RD x IDX_W  read select
//  rd_data     out  NUM_RD x 16     pair value
//  idu_en      in   1               apply +/-1 to pair idu_idx
//  idu_idx     in   IDX_W           IDU target pair
//  idu_dec     in   1               1=decrement, 0=increment
//  dump_start  in   1               start a register dump
//  dump_busy   out  1               dump in progress
//  dump_valid  out  1               dump beat valid
//  dump_ready  in   1               consumer accepts beat
//  dump_idx    out  IDX_W           pair index of current beat
//  dump_data   out  16              pair value of current beat
//  dump_last   out  1               current beat is index NUM_PAIRS-1
// BEHAVIOUR
//  - Reset (async, rst=1): all pairs 0, dump FSM IDLE; dump_busy/valid/last=0, dump_idx=0; rd_data = 0.
//  - Writes are registered: lane updates visible on rd_data the cycle after the edge.
//  - Per-lane priority, lowest->highest: IDU, wr port 0 .. wr port NUM_WR-1. Higher source overrides that lane only.
//  - IDU: new = old +/- 1 mod 2^16 (0xFFFF+1=0x0000, 0x0000-1=0xFFFF); both lanes written unless overridden.
//  - Index >= NUM_PAIRS on wr/idu: write dropped; on rd: returns 0.
//  - AF_IDX low byte: bits [3:0] always stored and read as 0 regardless of writer (incl. IDU result).
//  - Dump FSM states IDLE, RUN:
//      IDLE: dump_start=1 -> RUN, dump_idx=0. Outputs low.
//      RUN: dump_valid=dump_busy=1; dump_data = live stored value of dump_idx.
//        valid&ready & !last -> dump_idx+1. valid&ready & last -> IDLE (dump_idx=0).
//        dump_start ignored in RUN. dump_data may change while stalled if that pair is written;
//        consumer samples at handshake.
//  - Dump never blocks reads/writes/IDU. rst mid-dump -> IDLE immediately, no further beats.
// CONFIGURATION
//  SM83_RF_BYPASS_EN defined:
//    rd_data and dump_data return the post-priority-merge value being written this cycle
//    (same-cycle write-to-read forwarding, lane-accurate, F nibble still 0).
//  Undefined: rd_data/dump_data return stored value only; a same-cycle write appears next cycle.
// STRUCTURE
//  sm83_pkg additions:
//    rf_pair_idx_t;
//    constants PAIR_BC/DE/HL/AF/SP/PC;
//    rf_lane_t (2-bit lane mask);
//    rf_dump_state_t enum {RF_DUMP_IDLE, RF_DUMP_RUN}.
//  Sub-module sm83_rf_dump_seq: dump FSM + index counter; reads via an internal read tap.
//  Storage, priority merge, IDU adder and bypass stay in the top.
// TESTING
//  1. rst=1 then 0 -> all rd_data=0x0000, dump_valid=0.
//  2. Same cycle: IDU inc HL(0x00FF); wr0 HL lane[1]=0x12xx.
//     -> next cycle HL=0x1200 (IDU low 0x00, wr0 high 0x12).
//  3. wr0 and wr1 both BC, lane=11, data 0x1111/0x2222 -> BC=0x2222.
//     Write AF=0xABCD -> reads 0xABC0.
//  4. IDU dec SP=0x0000 -> 0xFFFF.
//     IDU inc PC=0xFFFF -> 0x0000.
//     wr_idx=7 (NUM_PAIRS=6) -> no pair changes.
//  5. dump_start with ready toggling 1,0,1,...
//     -> 6 beats idx 0..5 in order, data matches pairs, last on idx 5, then idle.
//     rst asserted at beat 2 -> valid drops immediately.
//  6. Write DE=0x5A5A and read DE same cycle.
//     -> 0x5A5A with SM83_RF_BYPASS_EN, old value without it.

Source files
------------

// File: rtl/sm83_pkg.sv
// sm83_pkg: shared register-file types, pair index constants and dump FSM states.
package sm83_pkg;
    localparam int RF_IDX_W = 3;
    typedef logic [RF_IDX_W-1:0] rf_pair_idx_t;
    localparam rf_pair_idx_t PAIR_BC = 3'd0;
    localparam rf_pair_idx_t PAIR_DE = 3'd1;
    localparam rf_pair_idx_t PAIR_HL = 3'd2;
    localparam rf_pair_idx_t PAIR_AF = 3'd3;
    localparam rf_pair_idx_t PAIR_SP = 3'd4;
    localparam rf_pair_idx_t PAIR_PC = 3'd5;
    typedef logic [1:0] rf_lane_t;
    typedef enum logic {RF_DUMP_IDLE, RF_DUMP_RUN} rf_dump_state_t;
endpackage

// File: rtl/sm83_rf_dump_seq.sv
// sm83_rf_dump_seq: walks every pair once with a valid/ready handshake, reading through a tap.
module sm83_rf_dump_seq
    import sm83_pkg::*;
#(
    parameter int NUM_PAIRS = 6,
    parameter int IDX_W     = $clog2(NUM_PAIRS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dump_start,
    input  logic             dump_ready,
    input  logic [15:0]      tap_data,
    output logic             dump_busy,
    output logic             dump_valid,
    output logic [IDX_W-1:0] dump_idx,
    output logic [15:0]      dump_data,
    output logic             dump_last
);
    rf_dump_state_t state, state_n;
    logic [IDX_W-1:0] idx_n;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RF_DUMP_IDLE;
            dump_idx <= '0;
        end else begin
            state    <= state_n;
            dump_idx <= idx_n;
        end
    end
    always_comb begin
        state_n   = state;
        idx_n     = dump_idx;
        dump_last = state == RF_DUMP_RUN && dump_idx == IDX_W'(NUM_PAIRS - 1);
        if (state == RF_DUMP_IDLE) begin
            state_n = dump_start ? RF_DUMP_RUN : RF_DUMP_IDLE;
            idx_n   = '0;
        end else if (dump_ready) begin
            state_n = dump_last ? RF_DUMP_IDLE : RF_DUMP_RUN;
            idx_n   = dump_last ? '0 : dump_idx + IDX_W'(1);
        end
    end
    assign dump_valid = state == RF_DUMP_RUN;
    assign dump_busy  = dump_valid;
    assign dump_data  = dump_valid ? tap_data : '0;
endmodule

// File: rtl/sm83_regfile_mp.sv
// sm83_regfile_mp: multi-port SM83 pair register file with byte-lane writes, IDU and dump port.
// Define SM83_RF_BYPASS_EN to forward this cycle's merged write data to rd_data/dump_data.
module sm83_regfile_mp
    import sm83_pkg::*;
#(
    parameter int NUM_PAIRS = 6,
    parameter int NUM_RD    = 3,
    parameter int NUM_WR    = 2,
    parameter int AF_IDX    = int'(PAIR_AF),
    parameter int IDX_W     = $clog2(NUM_PAIRS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_WR-1:0]              wr_en,
    input  logic [NUM_WR-1:0][IDX_W-1:0]   wr_idx,
    input  rf_lane_t [NUM_WR-1:0]          wr_lane,
    input  logic [NUM_WR-1:0][15:0]        wr_data,
    input  logic [NUM_RD-1:0][IDX_W-1:0]   rd_idx,
    output logic [NUM_RD-1:0][15:0]        rd_data,
    input  logic                           idu_en,
    input  logic [IDX_W-1:0]               idu_idx,
    input  logic                           idu_dec,
    input  logic                           dump_start,
    output logic                           dump_busy,
    output logic                           dump_valid,
    input  logic                           dump_ready,
    output logic [IDX_W-1:0]               dump_idx,
    output logic [15:0]                    dump_data,
    output logic                           dump_last
);
    logic [15:0] regs [NUM_PAIRS];
    logic [15:0] nxt  [NUM_PAIRS];
    logic [15:0] view [NUM_PAIRS];
    logic [15:0] tap_data;
    // Later sources overwrite earlier ones lane by lane: IDU first, then write ports in index order.
    always_comb begin
        for (int p = 0; p < NUM_PAIRS; p++) begin
            nxt[p] = regs[p];
            if (idu_en && idu_idx == IDX_W'(p))
                nxt[p] = idu_dec ? regs[p] - 16'd1 : regs[p] + 16'd1;
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && wr_idx[w] == IDX_W'(p) && wr_lane[w][1])
                    nxt[p][15:8] = wr_data[w][15:8];
                if (wr_en[w] && wr_idx[w] == IDX_W'(p) && wr_lane[w][0])
                    nxt[p][7:0] = wr_data[w][7:0];
            end
            if (p == AF_IDX)
                nxt[p][3:0] = 4'h0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PAIRS; p++)
                regs[p] <= '0;
        end else begin
            for (int p = 0; p < NUM_PAIRS; p++)
                regs[p] <= nxt[p];
        end
    end
`ifdef SM83_RF_BYPASS_EN
    assign view = nxt;
`else
    assign view = regs;
`endif
    // Indices with no matching pair fall through to zero.
    always_comb begin
        tap_data = '0;
        for (int r = 0; r < NUM_RD; r++)
            rd_data[r] = '0;
        for (int p = 0; p < NUM_PAIRS; p++) begin
            for (int r = 0; r < NUM_RD; r++)
                if (rd_idx[r] == IDX_W'(p))
                    rd_data[r] = view[p];
            if (dump_idx == IDX_W'(p))
                tap_data = view[p];
        end
    end
    sm83_rf_dump_seq #(.NUM_PAIRS(NUM_PAIRS), .IDX_W(IDX_W)) u_dump (
        .clk        (clk),
        .rst        (rst),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .tap_data   (tap_data),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_last  (dump_last)
    );
endmodule

// File: tb/tb_sm83_regfile_mp.sv
// tb_sm83_regfile_mp: directed vectors against a pair/byte model of the register file and dump port.
module tb_sm83_regfile_mp;
    localparam int NP = 6;
    localparam int NR = 3;
    localparam int NW = 2;
    localparam int IW = 3;
`ifdef SM83_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NW-1:0]         wr_en = '0;
    logic [NW-1:0][IW-1:0] wr_idx = '0;
    logic [NW-1:0][1:0]    wr_lane = '0;
    logic [NW-1:0][15:0]   wr_data = '0;
    logic [NR-1:0][IW-1:0] rd_idx = '0;
    logic [NR-1:0][15:0]   rd_data;
    logic                  idu_en = 1'b0;
    logic [IW-1:0]         idu_idx = '0;
    logic                  idu_dec = 1'b0;
    logic                  dump_start = 1'b0;
    logic                  dump_busy, dump_valid, dump_last;
    logic                  dump_ready = 1'b0;
    logic [IW-1:0]         dump_idx;
    logic [15:0]           dump_data;
    int vectors = 0;
    int miscompares = 0;
    logic [15:0] m_regs [NP];
    logic        m_run;
    int          m_idx;
    logic [15:0] exp_dump [NP] = '{16'h1122, 16'h0000, 16'h1200, 16'hABC0, 16'hFFFF, 16'h0000};

    sm83_regfile_mp dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_lane(wr_lane), .wr_data(wr_data),
        .rd_idx(rd_idx), .rd_data(rd_data),
        .idu_en(idu_en), .idu_idx(idu_idx), .idu_dec(idu_dec),
        .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data), .dump_last(dump_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Value a pair will hold after this edge, from the lane priority rules.
    function automatic logic [15:0] m_next(input int p);
        logic [15:0] v;
        logic [7:0] hi, lo;
        v = m_regs[p];
        if (idu_en && int'(idu_idx) == p) v = idu_dec ? v - 16'd1 : v + 16'd1;
        hi = v[15:8];
        lo = v[7:0];
        for (int w = 0; w < NW; w++) begin
            if (wr_en[w] && int'(wr_idx[w]) == p && wr_lane[w][1]) hi = wr_data[w][15:8];
            if (wr_en[w] && int'(wr_idx[w]) == p && wr_lane[w][0]) lo = wr_data[w][7:0];
        end
        if (p == 3) lo[3:0] = 4'h0;
        return {hi, lo};
    endfunction

    function automatic logic [15:0] m_view(input int p);
        if (p >= NP) return 16'h0000;
        return BYP ? m_next(p) : m_regs[p];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NP; p++) m_regs[p] <= 16'h0000;
            m_run <= 1'b0;
            m_idx <= 0;
        end else begin
            for (int p = 0; p < NP; p++) m_regs[p] <= m_next(p);
            if (m_run) begin
                if (dump_ready) begin
                    m_run <= m_idx != NP - 1;
                    m_idx <= m_idx == NP - 1 ? 0 : m_idx + 1;
                end
            end else if (dump_start) begin
                m_run <= 1'b1;
                m_idx <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NR; r++)
                chk($sformatf("rd%0d_idx%0d", r, rd_idx[r]), rd_data[r], m_view(int'(rd_idx[r])));
            chk("dump_valid", 16'(dump_valid), 16'(m_run));
            chk("dump_busy", 16'(dump_busy), 16'(m_run));
            chk("dump_idx", 16'(dump_idx), 16'(m_idx));
            chk("dump_last", 16'(dump_last), 16'(m_run && m_idx == NP - 1));
            chk("dump_data", dump_data, m_run ? m_view(m_idx) : 16'h0000);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        wr_en = '0;
        idu_en = 1'b0;
        dump_start = 1'b0;
    endtask

    task automatic wr(input int w, input int idx, input logic [1:0] lane, input logic [15:0] d);
        wr_en[w] = 1'b1;
        wr_idx[w] = IW'(idx);
        wr_lane[w] = lane;
        wr_data[w] = d;
    endtask

    task automatic peek(input int idx, input string name, input logic [15:0] exp);
        rd_idx[0] = IW'(idx);
        #1;
        chk(name, rd_data[0], exp);
    endtask

    initial begin
        bit done;
        int beats;
        logic rdy;
        rd_idx = {3'd2, 3'd1, 3'd0};
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        for (int r = 0; r < NR; r++) chk($sformatf("reset_rd%0d", r), rd_data[r], 16'h0000);
        chk("reset_dump_valid", 16'(dump_valid), 16'h0000);
        // IDU low byte and a high-lane write land together.
        wr(0, 2, 2'b11, 16'h00FF);
        tick();
        idu_en = 1'b1; idu_idx = 3'd2; idu_dec = 1'b0;
        wr(0, 2, 2'b10, 16'h12AB);
        tick();
        peek(2, "hl_idu_plus_hi_write", 16'h1200);
        wr(0, 0, 2'b11, 16'h1111);
        wr(1, 0, 2'b11, 16'h2222);
        tick();
        peek(0, "bc_port1_wins", 16'h2222);
        wr(0, 0, 2'b11, 16'h1111);
        wr(1, 0, 2'b01, 16'h2222);
        tick();
        peek(0, "bc_lane_merge", 16'h1122);
        wr(0, 3, 2'b11, 16'hABCD);
        tick();
        peek(3, "af_f_nibble", 16'hABC0);
        idu_en = 1'b1; idu_idx = 3'd3; idu_dec = 1'b0;
        tick();
        peek(3, "af_idu_nibble", 16'hABC0);
        idu_en = 1'b1; idu_idx = 3'd4; idu_dec = 1'b1;
        tick();
        peek(4, "sp_dec_wrap", 16'hFFFF);
        wr(0, 5, 2'b11, 16'hFFFF);
        tick();
        idu_en = 1'b1; idu_idx = 3'd5; idu_dec = 1'b0;
        tick();
        peek(5, "pc_inc_wrap", 16'h0000);
        wr(0, 7, 2'b11, 16'hDEAD);
        wr(1, 6, 2'b11, 16'hBEEF);
        idu_en = 1'b1; idu_idx = 3'd6;
        tick();
        rd_idx[1] = 3'd7;
        #1;
        chk("rd_out_of_range", rd_data[1], 16'h0000);
        rd_idx = {3'd5, 3'd4, 3'd3};
        // Full dump with a toggling consumer; a mid-run start is ignored.
        dump_start = 1'b1;
        tick();
        done = 1'b0;
        beats = 0;
        rdy = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            dump_ready = rdy;
            if (c == 3) dump_start = 1'b1;
            #1;
            if (dump_valid && dump_ready) begin
                chk($sformatf("dump_beat%0d_idx", beats), 16'(dump_idx), 16'(beats));
                chk($sformatf("dump_beat%0d_data", beats), dump_data, exp_dump[beats < NP ? beats : 0]);
                chk($sformatf("dump_beat%0d_last", beats), 16'(dump_last), 16'(beats == NP - 1));
                done = dump_last;
                beats++;
            end
            rdy = !rdy;
            tick();
        end
        chk("dump_beat_count", 16'(beats), 16'(NP));
        dump_ready = 1'b0;
        #1;
        chk("dump_idle_after", 16'(dump_busy), 16'h0000);
        // Reset in the middle of a dump.
        dump_start = 1'b1;
        tick();
        dump_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            #1;
            done = dump_idx == 3'd2;
            if (!done) tick();
        end
        chk("dump_reached_beat2", 16'(done), 16'h0001);
        rst = 1'b1;
        #1;
        chk("rst_mid_dump_valid", 16'(dump_valid), 16'h0000);
        chk("rst_mid_dump_idx", 16'(dump_idx), 16'h0000);
        dump_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        peek(2, "hl_cleared_by_rst", 16'h0000);
        // Same-cycle write then read of DE.
        wr(0, 1, 2'b11, 16'h5A5A);
        peek(1, "de_same_cycle", BYP ? 16'h5A5A : 16'h0000);
        tick();
        peek(1, "de_next_cycle", 16'h5A5A);
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
